// File: rtl/dpt_pkg.sv
// Shared types and timing constants for the double-pulse burst scheduler.
// Clock is 40 MHz, so one cycle is 25 ns.
package dpt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        ON,
        OFF,
        COOL,
        FAULT
    } state_t;

    localparam int CLK_HZ = 40_000_000;
    localparam int US_5   = 200;
    localparam int US_20  = 800;
    localparam int US_30  = 1200;
    localparam int S_5    = 200_000_000;

endpackage

// File: rtl/dpt_trig_sync.sv
// Two-flop synchroniser for the asynchronous trigger, plus a rising-edge
// detector on the synchronised level.
module dpt_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s2_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= trig;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/dpt_burst_scheduler.sv
// Programmable multi-pulse gate-drive burst on one half-bridge leg, with dead
// time, enable gating of pulses 2..N, fault abort and post-burst lockout.
module dpt_burst_scheduler
    import dpt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int NP_W     = 3,
    parameter int DEAD_CYC = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             enable,
    input  logic             fault,
    input  logic             cfg_leg,
    input  logic [NP_W-1:0]  cfg_n_pulse,
    input  logic [CNT_W-1:0] cfg_t_on1,
    input  logic [CNT_W-1:0] cfg_t_on,
    input  logic [CNT_W-1:0] cfg_t_off,
    input  logic [CNT_W-1:0] cfg_t_cool,
    output logic             K1,
    output logic             K2,
    output logic             busy,
    output logic             done,
    output logic             faulted,
    output logic [NP_W-1:0]  pulse_idx
);

    localparam logic [CNT_W-1:0] DEAD_LEN = CNT_W'(DEAD_CYC);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, phase_len;
    logic [CNT_W-1:0] t_on1_q, t_on_q, t_off_q, t_cool_q;
    logic [NP_W-1:0]  n_q, idx, idx_n;
    logic             leg_q;
    logic             s2, rise, start, phase_end, drive, done_n;

    dpt_trig_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig),
        .s2   (s2),
        .rise (rise)
    );

    // A phase programmed with 0 still lasts one cycle.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    assign start = rise && (state == IDLE) && (cfg_n_pulse != '0);

    always_comb begin
        phase_len = '0;
        case (state)
            DEAD:    phase_len = DEAD_LEN;
            ON:      phase_len = (idx == NP_W'(1)) ? t_on1_q : t_on_q;
            OFF:     phase_len = t_off_q;
            COOL:    phase_len = t_cool_q;
            default: phase_len = '0;
        endcase
    end

    assign phase_end = (cnt == last_cnt(phase_len));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        if (fault) begin
            state_n = FAULT;
        end else begin
            unique case (state)
                IDLE: if (start) state_n = DEAD;
                DEAD: if (phase_end) begin
                    state_n = ON;
                    idx_n   = NP_W'(1);
                end
                ON:   if (phase_end) state_n = (idx == n_q) ? COOL : OFF;
                OFF:  if (phase_end) begin
                    state_n = ON;
                    idx_n   = idx + 1'b1;
                end
                COOL: if (phase_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
                FAULT: if (!s2) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        if (state_n == IDLE || state_n == FAULT) idx_n = '0;
        // Counter restarts on every state change and rests at 0 when parked.
        if (state_n != state || state_n == IDLE || state_n == FAULT)
            cnt_n = '0;
        else
            cnt_n = cnt + 1'b1;
        drive = (state_n == ON) && ((idx_n == NP_W'(1)) || enable);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            n_q       <= '0;
            leg_q     <= 1'b0;
            t_on1_q   <= '0;
            t_on_q    <= '0;
            t_off_q   <= '0;
            t_cool_q  <= '0;
            K1        <= 1'b0;
            K2        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            faulted   <= 1'b0;
            pulse_idx <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            K1        <= drive & ~leg_q;
            K2        <= drive & leg_q;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            faulted   <= (state_n == FAULT);
            pulse_idx <= (state_n == ON) ? idx_n : '0;
            if (start) begin
                n_q      <= cfg_n_pulse;
                leg_q    <= cfg_leg;
                t_on1_q  <= cfg_t_on1;
                t_on_q   <= cfg_t_on;
                t_off_q  <= cfg_t_off;
                t_cool_q <= cfg_t_cool;
            end
        end
    end

endmodule

// File: tb/tb_dpt_burst_scheduler.sv
// Bench for dpt_burst_scheduler: per-edge waveform capture compared with a
// pulse-schedule model built from phase lengths.
`timescale 1ns/100ps
module tb_dpt_burst_scheduler;

    localparam int D    = 4;
    localparam int MAXC = 700;

    logic        clk = 1'b0, rst_n = 1'b0, trig = 1'b0, enable = 1'b0, fault = 1'b0;
    logic        cfg_leg = 1'b0;
    logic [2:0]  cfg_n_pulse = '0;
    logic [31:0] cfg_t_on1 = '0, cfg_t_on = '0, cfg_t_off = '0, cfg_t_cool = '0;
    logic        K1, K2, busy, done, faulted;
    logic [2:0]  pulse_idx;

    int n_assert = 0, n_fail = 0;
    int c_leg, c_n, c_on1, c_on, c_off, c_cool, last_done;

    bit         en_tab[MAXC], trig_tab[MAXC], flt_tab[MAXC], rst_tab[MAXC];
    logic [7:0] obs[MAXC];
    bit         ek1[MAXC], ek2[MAXC], ebusy[MAXC], edone[MAXC], eflt[MAXC];
    logic [2:0] eidx[MAXC];

    dpt_burst_scheduler #(.CNT_W(32), .NP_W(3), .DEAD_CYC(D)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .enable(enable), .fault(fault),
        .cfg_leg(cfg_leg), .cfg_n_pulse(cfg_n_pulse), .cfg_t_on1(cfg_t_on1),
        .cfg_t_on(cfg_t_on), .cfg_t_off(cfg_t_off), .cfg_t_cool(cfg_t_cool),
        .K1(K1), .K2(K2), .busy(busy), .done(done), .faulted(faulted),
        .pulse_idx(pulse_idx)
    );

    always #12.5 clk = ~clk;

    always @(negedge clk) begin
        if (K1 | K2) begin
            n_assert++;
            if (K1 & K2) begin
                n_fail++;
                $display("FAIL both_legs at %0t: K1=%b K2=%b, want never both 1", $time, K1, K2);
            end
        end
    end

    task automatic clear_tabs();
        for (int e = 0; e < MAXC; e++) begin
            en_tab[e] = 0; trig_tab[e] = 0; flt_tab[e] = 0; rst_tab[e] = 0;
            obs[e] = '0; ek1[e] = 0; ek2[e] = 0; ebusy[e] = 0; edone[e] = 0;
            eflt[e] = 0; eidx[e] = '0;
        end
    endtask

    task automatic set_cfg(input int leg, input int n, input int on1, input int on,
                           input int off, input int cool);
        c_leg = leg; c_n = n; c_on1 = on1; c_on = on; c_off = off; c_cool = cool;
    endtask

    // Drive tables edge by edge; cfg pins carry junk on edges 5..14 so a
    // running burst must rely on its latched copy.
    task automatic capture(input int ncyc);
        for (int e = 1; e <= ncyc; e++) begin
            trig = trig_tab[e]; enable = en_tab[e]; fault = flt_tab[e]; rst_n = !rst_tab[e];
            if (e >= 5 && e < 15) begin
                cfg_leg = 1'($urandom); cfg_n_pulse = 3'($urandom);
                cfg_t_on1 = $urandom; cfg_t_on = $urandom;
                cfg_t_off = $urandom; cfg_t_cool = $urandom;
            end else begin
                cfg_leg = 1'(c_leg); cfg_n_pulse = 3'(c_n);
                cfg_t_on1 = 32'(c_on1); cfg_t_on = 32'(c_on);
                cfg_t_off = 32'(c_off); cfg_t_cool = 32'(c_cool);
            end
            @(posedge clk); #1;
            obs[e] = {K1, K2, busy, done, faulted, pulse_idx};
        end
        trig = 0; fault = 0; rst_n = 1; enable = 0;
    endtask

    // Expected schedule for a burst whose trigger is first sampled high at edge s.
    task automatic model_burst(input int s);
        int t, len, k;
        t = s + 2 + D;
        for (int p = 1; p <= c_n; p++) begin
            len = (p == 1) ? c_on1 : c_on;
            if (len < 1) len = 1;
            for (int e = t; e < t + len; e++) begin
                k = (p == 1) ? 1 : int'(en_tab[e]);
                ek1[e] = (k == 1) && (c_leg == 0);
                ek2[e] = (k == 1) && (c_leg == 1);
                eidx[e] = 3'(p);
            end
            t += len;
            if (p < c_n) t += (c_off < 1) ? 1 : c_off;
        end
        last_done = t + ((c_cool < 1) ? 1 : c_cool);
        for (int e = s + 2; e < last_done; e++) ebusy[e] = 1;
        edone[last_done] = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; trig = 1; enable = 1; cfg_n_pulse = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        n_assert++; if (K1 !== 1'b0) begin n_fail++; $display("FAIL reset_K1: got %b want 0", K1); end
        n_assert++; if (K2 !== 1'b0) begin n_fail++; $display("FAIL reset_K2: got %b want 0", K2); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_assert++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL reset_faulted: got %b want 0", faulted); end
        n_assert++; if (pulse_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", pulse_idx); end
        trig = 0; rst_n = 1; enable = 0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_double_pulse();
        logic [7:0] ex;
        clear_tabs();
        set_cfg(0, 2, 12, 12, 8, 20);
        for (int e = 0; e < MAXC; e++) en_tab[e] = 1;
        trig_tab[1] = 1; trig_tab[2] = 1;
        model_burst(1);
        capture(last_done + 5);
        for (int e = 1; e <= last_done + 5; e++) begin
            ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
            n_assert++;
            if (obs[e] !== ex) begin n_fail++; $display("FAIL double_pulse edge %0d: got %b want %b", e, obs[e], ex); end
        end
        n_assert++;
        if (obs[7][7] !== 1'b1 || obs[6][7] !== 1'b0) begin
            n_fail++; $display("FAIL first_rise: K1 at edge6=%b edge7=%b want 0,1", obs[6][7], obs[7][7]);
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] ex;
        for (int pass = 0; pass < 2; pass++) begin
            clear_tabs();
            set_cfg(0, 2, 12, 12, 8, 20);
            // pass 0: enable low throughout; pass 1: enable toggles during pulse 2
            for (int e = 0; e < MAXC; e++) en_tab[e] = (pass == 1) ? bit'($urandom) : 1'b0;
            trig_tab[1] = 1; trig_tab[2] = 1;
            model_burst(1);
            capture(last_done + 5);
            for (int e = 1; e <= last_done + 5; e++) begin
                ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
                n_assert++;
                if (obs[e] !== ex) begin n_fail++; $display("FAIL enable_gating%0d edge %0d: got %b want %b", pass, e, obs[e], ex); end
            end
        end
    endtask

    task automatic test_leg_zero();
        logic [7:0] ex;
        clear_tabs();
        set_cfg(1, 3, 5, 0, 3, 4);
        for (int e = 0; e < MAXC; e++) en_tab[e] = 1;
        trig_tab[1] = 1; trig_tab[2] = 1;
        model_burst(1);
        capture(last_done + 5);
        for (int e = 1; e <= last_done + 5; e++) begin
            ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
            n_assert++;
            if (obs[e] !== ex) begin n_fail++; $display("FAIL leg_k2 edge %0d: got %b want %b", e, obs[e], ex); end
        end
        clear_tabs();
        set_cfg(0, 0, 12, 12, 8, 20);
        trig_tab[1] = 1; trig_tab[2] = 1;
        capture(20);
        for (int e = 1; e <= 20; e++) begin
            n_assert++;
            if (obs[e] !== 8'h00) begin n_fail++; $display("FAIL zero_pulses edge %0d: got %b want 00000000", e, obs[e]); end
        end
    endtask

    task automatic test_fault();
        logic [7:0] ex;
        int x;
        clear_tabs();
        set_cfg(0, 2, 12, 12, 8, 20);
        for (int e = 0; e < MAXC; e++) en_tab[e] = 1;
        trig_tab[1] = 1; trig_tab[2] = 1;
        for (int e = 32; e <= 40; e++) flt_tab[e] = 1;
        for (int e = 34; e <= 43; e++) trig_tab[e] = 1;
        model_burst(1);
        // Leaves FAULT on the first edge with fault low and synchronised trig low.
        x = 33;
        while (flt_tab[x] || trig_tab[x-2]) x++;
        for (int e = 32; e < MAXC; e++) begin
            ek1[e] = 0; ek2[e] = 0; edone[e] = 0; eidx[e] = '0;
            eflt[e] = (e < x); ebusy[e] = (e < x);
        end
        capture(70);
        for (int e = 1; e <= 70; e++) begin
            ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
            n_assert++;
            if (obs[e] !== ex) begin n_fail++; $display("FAIL fault_abort edge %0d: got %b want %b", e, obs[e], ex); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex;
        int dn, r2, r;
        clear_tabs();
        set_cfg(0, 2, 12, 12, 8, 20);
        for (int e = 0; e < MAXC; e++) en_tab[e] = 1;
        trig_tab[1] = 1; trig_tab[2] = 1;
        model_burst(1);
        dn = last_done;
        // Short trigger pulses that land while busy must be discarded.
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(4, dn - 3);
            trig_tab[r] = 1;
        end
        trig_tab[dn-3] = 1;
        r2 = dn + 5;
        trig_tab[r2] = 1; trig_tab[r2+1] = 1;
        model_burst(r2);
        capture(last_done + 5);
        for (int e = 1; e <= last_done + 5; e++) begin
            ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
            n_assert++;
            if (obs[e] !== ex) begin n_fail++; $display("FAIL retrigger edge %0d: got %b want %b", e, obs[e], ex); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ex;
        clear_tabs();
        set_cfg(0, 2, 12, 12, 8, 20);
        for (int e = 0; e < MAXC; e++) en_tab[e] = 1;
        trig_tab[1] = 1; trig_tab[2] = 1;
        rst_tab[22] = 1;
        model_burst(1);
        for (int e = 22; e < MAXC; e++) begin
            ek1[e] = 0; ek2[e] = 0; ebusy[e] = 0; edone[e] = 0; eflt[e] = 0; eidx[e] = '0;
        end
        trig_tab[30] = 1; trig_tab[31] = 1;
        model_burst(30);
        capture(last_done + 5);
        for (int e = 1; e <= last_done + 5; e++) begin
            ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
            n_assert++;
            if (obs[e] !== ex) begin n_fail++; $display("FAIL reset_mid edge %0d: got %b want %b", e, obs[e], ex); end
        end
    endtask

    task automatic test_random();
        logic [7:0] ex;
        for (int it = 0; it < 8; it++) begin
            clear_tabs();
            set_cfg(int'($urandom_range(0, 1)), int'($urandom_range(1, 7)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
            for (int e = 0; e < MAXC; e++) en_tab[e] = bit'($urandom);
            trig_tab[1] = 1; trig_tab[2] = 1;
            model_burst(1);
            capture(last_done + 5);
            for (int e = 1; e <= last_done + 5; e++) begin
                ex = {ek1[e], ek2[e], ebusy[e], edone[e], eflt[e], eidx[e]};
                n_assert++;
                if (obs[e] !== ex) begin n_fail++; $display("FAIL random%0d edge %0d: got %b want %b", it, e, obs[e], ex); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_double_pulse();
        test_enable_gating();
        test_leg_zero();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
